// File: rtl/wta_subpix_prep.sv
// Winner-take-all over one pixel's cost stream; emits dividend/divisor for the subpixel divider.
// The edge flag port is named edge_flag because "edge" is a reserved SystemVerilog keyword.
module wta_subpix_prep #(
  parameter int CostW    = 16,
  parameter int NumDisp  = 64,
  parameter int DispW    = 7,
  parameter int FracBits = 4,
  parameter int WidthD0  = 32,
  parameter int WidthD1  = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cost_valid,
  input  logic [CostW-1:0]   cost,
  output logic               out_valid,
  output logic [WidthD0-1:0] div_a,
  output logic [WidthD1-1:0] div_b,
  output logic [DispW-1:0]   d_min,
  output logic [CostW-1:0]   c_min_out,
  output logic               sub_neg,
  output logic               edge_flag
);

  localparam logic [DispW-1:0] LastD = DispW'(NumDisp - 1);

  logic [DispW-1:0] d_cnt;
  logic [DispW-1:0] d_min_q;
  logic [CostW-1:0] c_min, c_prev, c_next, last_cost;
  logic             next_pend;

  // Tracking state as it stands after the current beat is folded in
  logic [DispW-1:0] t_dmin;
  logic [CostW-1:0] t_min, t_prev, t_next;
  logic             t_pend;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    t_min  = c_min;
    t_dmin = d_min_q;
    t_prev = c_prev;
    t_next = c_next;
    t_pend = next_pend;
    if (d_cnt == '0) begin
      t_min  = cost;
      t_dmin = '0;
      t_prev = '0;
      t_pend = 1'b1;
    end else if (cost < c_min) begin
      // Strict compare keeps the lowest d on ties; a new minimum re-arms the c_next capture
      t_min  = cost;
      t_dmin = d_cnt;
      t_prev = last_cost;
      t_pend = 1'b1;
    end else if (next_pend) begin
      t_next = cost;
      t_pend = 1'b0;
    end
  end

  logic             r_edge;
  logic [CostW:0]   diff, mag;
  logic [CostW+1:0] den;
  logic [WidthD0-1:0] r_div_a;
  logic [WidthD1-1:0] r_div_b;

  always_comb begin
    r_edge = (t_dmin == '0) || (t_dmin == LastD);
    diff   = {1'b0, t_prev} - {1'b0, t_next};
    mag    = diff[CostW] ? (~diff + (CostW+1)'(1)) : diff;
    // c_min is the minimum, so this never goes negative
    den    = {2'b00, t_prev} + {2'b00, t_next} - {1'b0, t_min, 1'b0};
    r_div_a = WidthD0'(mag) << FracBits;
    r_div_b = (den == '0) ? WidthD1'(1) : WidthD1'({den, 1'b0});
    if (r_edge) begin
      r_div_a = '0;
      r_div_b = WidthD1'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_cnt     <= '0;
      d_min_q   <= '0;
      c_min     <= '0;
      c_prev    <= '0;
      c_next    <= '0;
      last_cost <= '0;
      next_pend <= 1'b0;
      out_valid <= 1'b0;
      div_a     <= '0;
      div_b     <= WidthD1'(1);
      d_min     <= '0;
      c_min_out <= '0;
      sub_neg   <= 1'b0;
      edge_flag <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (cost_valid) begin
        c_min     <= t_min;
        d_min_q   <= t_dmin;
        c_prev    <= t_prev;
        c_next    <= t_next;
        next_pend <= t_pend;
        last_cost <= cost;
        d_cnt     <= (d_cnt == LastD) ? '0 : d_cnt + DispW'(1);
        if (d_cnt == LastD) begin
          out_valid <= 1'b1;
          div_a     <= r_div_a;
          div_b     <= r_div_b;
          d_min     <= t_dmin;
          c_min_out <= t_min;
          sub_neg   <= ~r_edge & diff[CostW];
          edge_flag <= r_edge;
        end
      end
    end
  end

endmodule

// File: tb/tb_wta_subpix_prep.sv
// Random and directed pixels checked against a per-pixel array model of the winner-take-all rules.
module tb_wta_subpix_prep;
  localparam int CW = 16, ND = 8, DW = 3, FB = 4, W0 = 32, W1 = 20;

  logic          clk = 1'b0;
  logic          rst, cost_valid;
  logic [CW-1:0] cost;
  logic          out_valid, sub_neg, edge_flag;
  logic [W0-1:0] div_a;
  logic [W1-1:0] div_b;
  logic [DW-1:0] d_min;
  logic [CW-1:0] c_min_out;

  wta_subpix_prep #(.CostW(CW), .NumDisp(ND), .DispW(DW), .FracBits(FB),
                    .WidthD0(W0), .WidthD1(W1)) dut (
    .clk(clk), .rst(rst), .cost_valid(cost_valid), .cost(cost),
    .out_valid(out_valid), .div_a(div_a), .div_b(div_b), .d_min(d_min),
    .c_min_out(c_min_out), .sub_neg(sub_neg), .edge_flag(edge_flag));

  always #5 clk = ~clk;

  typedef struct {
    int dmin; int cmin; longint a; longint b; int neg; int edg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  logic final_beat;

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Global minimum (lowest index on ties) with its two array neighbours
  function automatic exp_t model(input int c[ND]);
    exp_t e;
    int m, p, n, diff, den;
    m = 0;
    for (int i = 1; i < ND; i++) if (c[i] < c[m]) m = i;
    e.dmin = m;
    e.cmin = c[m];
    e.edg  = (m == 0 || m == ND - 1) ? 1 : 0;
    if (e.edg == 1) begin
      e.a = 0; e.b = 1; e.neg = 0;
    end else begin
      p = c[m-1];
      n = c[m+1];
      diff  = p - n;
      e.neg = (diff < 0) ? 1 : 0;
      e.a   = longint'((diff < 0) ? -diff : diff) * (1 << FB);
      den   = p + n - 2 * c[m];
      e.b   = (den == 0) ? 1 : 2 * den;
    end
    return e;
  endfunction

  task automatic idle();
    @(posedge clk); #1;
    cost_valid = 1'b0;
    final_beat = 1'b0;
    cost       = CW'($urandom);
  endtask

  task automatic beat(input int c, input bit fin);
    @(posedge clk); #1;
    cost_valid = 1'b1;
    cost       = CW'(c);
    final_beat = fin;
  endtask

  task automatic send_pixel(input int c[ND], input int gap, input bit rand_gap);
    for (int i = 0; i < ND; i++) begin
      beat(c[i], i == ND - 1);
      if (i == ND - 1) exp_q.push_back(model(c));
      if (i != ND - 1) repeat (rand_gap ? $urandom_range(0, gap) : gap) idle();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_div_a"}, div_a, 0);
    check({tag, "_div_b"}, div_b, 1);
    check({tag, "_d_min"}, d_min, 0);
    check({tag, "_c_min"}, c_min_out, 0);
    check({tag, "_sub_neg"}, sub_neg, 0);
    check({tag, "_edge"}, edge_flag, 0);
  endtask

  // Cycle monitor: out_valid timing, result fields on strobes, hold between strobes
  bit   exp_ov = 1'b0, have_last = 1'b0;
  exp_t last;
  always @(negedge clk) begin
    exp_t e;
    check("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      check("queue_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("d_min", d_min, e.dmin);
        check("c_min_out", c_min_out, e.cmin);
        check("div_a", div_a, e.a);
        check("div_b", div_b, e.b);
        check("sub_neg", sub_neg, e.neg);
        check("edge", edge_flag, e.edg);
        last = e;
        have_last = 1'b1;
      end
    end else if (have_last) begin
      check("hold_d_min", d_min, last.dmin);
      check("hold_div_b", div_b, last.b);
    end
    if (rst) have_last = 1'b0;
    exp_ov = cost_valid && final_beat && !rst;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  int px[ND];
  initial begin
    rst = 1'b1; cost_valid = 1'b0; final_beat = 1'b0; cost = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    px = '{50, 40, 30, 20, 26, 35, 40, 60}; send_pixel(px, 0, 0);
    px = '{60, 40, 20, 30, 35, 36, 37, 38}; send_pixel(px, 0, 0);
    px = '{60, 30, 20, 40, 50, 50, 50, 50}; send_pixel(px, 0, 0);
    px = '{5, 9, 9, 9, 9, 9, 9, 9};         send_pixel(px, 0, 0);
    px = '{9, 9, 9, 9, 9, 9, 9, 4};         send_pixel(px, 0, 0);
    px = '{30, 10, 20, 10, 25, 30, 30, 30}; send_pixel(px, 0, 0);
    idle(); idle();

    px = '{50, 40, 30, 20, 26, 35, 40, 60};
    send_pixel(px, 3, 0);
    repeat (3) idle();
    send_pixel(px, 3, 0);
    send_pixel(px, 0, 0);
    send_pixel(px, 0, 0);
    idle(); idle();

    // Abort a pixel after beat d=4 with a one-cycle reset
    px = '{11, 7, 3, 9, 15, 1, 1, 1};
    for (int i = 0; i < 5; i++) beat(px[i], 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; cost_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("abort");
    px = '{50, 40, 30, 20, 26, 35, 40, 60}; send_pixel(px, 0, 0);

    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < ND; i++)
        px[i] = (k % 2 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 65535));
      send_pixel(px, 2, 1);
      if ($urandom_range(0, 3) == 0) idle();
    end

    repeat (4) idle();
    check("drain_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wta_subpix_prep.md
Name: wta_subpix_prep

Overview:
- Winner-take-all stage that sits directly upstream of the pipelined shift-subtract divider.
- Consumes the aggregated SGBM cost stream, one cost per cycle and NumDisp costs per pixel. Finds the minimum-cost disparity and its two neighbour costs.
- Produces the unsigned dividend/divisor pair for the subpixel correction, plus sideband fields (integer disparity, sign, edge flag).
- Downstream logic delays the sideband by the divider latency (WidthD0+1 cycles) and applies the quotient as a fraction in units of 2^-FracBits pixel.

Parameters:
- CostW, 16, width of one aggregated cost (unsigned).
- NumDisp, 64, disparities per pixel; minimum 3.
- DispW, 7, width of the disparity index; must satisfy 2^DispW >= NumDisp.
- FracBits, 4, subpixel fraction bits; dividend is pre-shifted by this amount.
- WidthD0, 32, dividend width; must be >= CostW+FracBits.
- WidthD1, 20, divisor width; must be >= CostW+3.

Ports:
- clk, input, 1, sole clock.
- rst, input, 1, synchronous active-high reset.
- cost_valid, input, 1, cost is valid this cycle.
- cost, input, CostW, aggregated cost; d increments per valid beat from 0 to NumDisp-1, then wraps to the next pixel.
- out_valid, output, 1, one-cycle strobe: div_a/div_b/sideband valid.
- div_a, output, WidthD0, dividend, equal to |c_prev - c_next| << FracBits.
- div_b, output, WidthD1, divisor, equal to 2*(c_prev + c_next - 2*c_min), forced >= 1.
- d_min, output, DispW, integer winning disparity.
- c_min_out, output, CostW, winning cost.
- sub_neg, output, 1, 1 when c_next > c_prev, i.e. the correction is negative.
- edge, output, 1, winner is at d=0 or d=NumDisp-1; no interpolation.

Behaviour:
- Reset: synchronous, active-high, on clk. All outputs are 0, except div_b = 1. The disparity counter clears to 0 and any partial pixel is discarded. Reset asserted mid-pixel means the next valid beat after release is d=0.
- Counter: advances only on cost_valid. It wraps NumDisp-1 -> 0. Gaps in cost_valid stall the stage with no state change.
- Min tracking, per valid beat at index d:
  - d==0: load c_min=cost, d_min=0, c_prev=0, next_pend=1.
  - d>0 and cost < c_min (strict, so ties keep the lowest d): load c_min=cost, d_min=d, c_prev=the cost of beat d-1 (registered last cost), next_pend=1.
  - Otherwise, if next_pend: c_next=cost, next_pend=0.
- Neighbours: a new minimum at d+1 supersedes the pending c_next capture. Its c_prev is the old minimum.
- Finalise: on the beat with d==NumDisp-1, the evaluation above is included and the results register on the next clk. out_valid pulses high for exactly 1 cycle, 1 cycle after that last beat.
- Throughput: back-to-back pixels with no gap are supported. A pixel's d=0 beat may coincide with the out_valid cycle of the previous pixel; the outputs hold the previous result independently.
- Output values:
  - edge = (d_min==0) or (d_min==NumDisp-1).
  - If edge: div_a=0, div_b=1, sub_neg=0.
  - Otherwise: diff = c_prev - c_next, computed in CostW+1 bits signed; sub_neg = diff<0; div_a = |diff| zero-extended then << FracBits.
  - Denominator: den = c_prev + c_next - 2*c_min, computed in CostW+2 bits; always >= 0 because c_min is the minimum. div_b = den<<1 zero-extended, or 1 if den==0 (guard; unreachable with strict-less ties, since c_prev > c_min).
- Outputs hold their value between strobes. They are not cleared after the out_valid pulse.
- No backpressure: the divider accepts one operand pair per cycle. out_valid is informational for the sideband delay line.

Test Plan:
- NumDisp=8, costs 50,40,30,20,26,35,40,60 back-to-back -> 1 cycle after last beat: out_valid=1 for 1 cycle, d_min=3, c_min_out=20, div_a=64, div_b=32, sub_neg=0, edge=0.
- Costs 60,40,20,30,35,36,37,38 -> d_min=2, div_a=(40-30)<<4=160, div_b=2*(40+30-40)=60, sub_neg=0; then 60,30,20,40,50,50,50,50 -> d_min=2, div_a=160, div_b=60, sub_neg=1.
- Costs 5,9,9,9,9,9,9,9 -> d_min=0, edge=1, div_a=0, div_b=1. Costs 9,9,9,9,9,9,9,4 -> d_min=7, edge=1, div_a=0, div_b=1.
- Tie case: costs 30,10,20,10,25,30,30,30 -> d_min=1 (lowest d), div_a=(30-20)<<4=160, div_b=2*(30+20-20)=60.
- Scenario 1 with cost_valid deasserted 3 cycles between each beat, and two pixels sent with no gap -> identical results per pixel; out_valid pulses exactly once per pixel, 1 cycle after each last beat.
- Assert rst for 1 cycle after beat d=4 of a pixel, then send a full 8-beat pixel -> no out_valid for the aborted pixel; the new pixel's result is correct. During reset, div_b=1 and all other outputs are 0.
